interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Interrupt controller for the pong system: the responder side of the processor's `INT_IRQ`/`INT_IACK`/`INT_IEND` handshake. It generates the periodic system-timer interrupt and buffers keystrokes arriving from the keyboard front-end. It presents one request at a time to the game processor and holds the key code stable while the keyboard interrupt is serviced. It sits between the keyboard decoder and the processor and drives `KBD_KEY` and `INT_IRQ`.

## Interface
- `TIMER_DIV`, default 16'd50000: system-timer period in clock cycles; legal range 2..65535.
- `KBD_FIFO_DEPTH`, default 4: keystroke buffer depth; power of two, 2..16. Used only when `INTC_KBD_FIFO_EN` is defined.
- `CLK`  in  1  system clock.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `ENABLE`  in  1  when low, no new request leaves IDLE; the timer and the keystroke buffer keep running.
- `KBD_STROBE`  in  1  one-cycle pulse; `KBD_CODE` is valid in that cycle.
- `KBD_CODE`  in  8  ASCII code from the keyboard decoder.
- `INT_IRQ`  out  2  request code: 2'b00 timer, 2'b01 keyboard, 2'b11 none; 2'b10 is never driven.
- `INT_IACK`  in  1  processor acknowledge.
- `INT_IEND`  in  1  processor end-of-interrupt.
- `KBD_KEY`  out  8  head of the keystroke buffer.
- `TIMER_OVERRUN`  out  1  sticky: a timer tick arrived while the timer was already pending.
- `KBD_OVERFLOW`  out  1  sticky: a strobe arrived while the buffer was full.
- `CLEAR_FLAGS`  in  1  synchronous clear of both sticky flags.

## Operation
- **Timer**
  - 16-bit counter runs 0..`TIMER_DIV`-1 and wraps.
  - The cycle at `TIMER_DIV`-1 is a tick, and the tick sets `timerPend`.
  - A tick while `timerPend` is already 1 sets `TIMER_OVERRUN`.
  - The counter ignores `ENABLE`.
- **Keystroke buffer**
  - A strobe pushes `KBD_CODE`.
  - A strobe while the buffer is full drops the code and sets `KBD_OVERFLOW`.
  - `kbdPend` = buffer not empty.
  - `KBD_KEY` = head entry, or 8'h00 when empty.
- **FSM** (`SEL` = latched source):
  - **IDLE:** `INT_IRQ`=2'b11. If `ENABLE` and any source is pending, latch `SEL` and go to REQ. Timer has priority over keyboard.
  - **REQ:** `INT_IRQ`=code of `SEL`. On `INT_IACK`, go to SVC.
  - **SVC:** `INT_IRQ`=2'b11. On `INT_IEND`, do the following and return to IDLE:
    - If `SEL` is timer, clear `timerPend`.
    - If `SEL` is keyboard, pop the buffer.
- **Boundary rules**
  - A tick in the same cycle as a timer `INT_IEND` leaves `timerPend`=1, with no overrun flagged.
  - Push and pop in the same cycle both take effect; on a full buffer, push+pop is not an overflow.
  - `INT_IACK` outside REQ is ignored; `INT_IEND` outside SVC is ignored.
  - `CLEAR_FLAGS` and a same-cycle set event: the set wins.
  - `ENABLE` low during REQ/SVC does not abort the current transaction.
- **Reset** (`RESET_N` low, asynchronous, including mid-transaction):
  - state IDLE, counter 0, buffer empty, both pend bits 0;
  - `INT_IRQ`=2'b11, `KBD_KEY`=8'h00, both flags 0.

## Timing
- All state is registered.
- `INT_IRQ` is decoded from the state and `SEL` registers only, so it is glitch-free.
- Strobe in cycle N: the buffer is non-empty at N+1, the FSM enters REQ at N+2, and `INT_IRQ`=2'b01 at N+2.
- Tick in cycle N: `timerPend` at N+1, `INT_IRQ`=2'b00 at N+2.
- `INT_IACK` in cycle M: `INT_IRQ`=2'b11 from M+1.
- `KBD_KEY` is unchanged from REQ entry until the cycle after `INT_IEND`, so the processor's capture one cycle after `INT_IACK` is valid.
- After `INT_IEND` there is at least one IDLE cycle with 2'b11 before the next request.
- Back-to-back service throughput: one request per 3 FSM cycles plus processor latency.

## Configuration
- `INTC_KBD_FIFO_EN` defined: the keystroke buffer is a FIFO of `KBD_FIFO_DEPTH` entries, with `log2` pointers plus a count.
- Not defined: the buffer is a single holding register (depth 1). A strobe while it is occupied is an overflow; all other behaviour is identical.

## Structure
- Package `intc_pkg`:
  - `IRQ_TIMER`=2'b00, `IRQ_KBD`=2'b01, `IRQ_NONE`=2'b11;
  - FSM state enum IDLE/REQ/SVC;
  - source enum for `SEL`.
- Sub-module `intc_key_fifo`:
  - parameterised depth;
  - ports push/pop/data in, head/empty/full out;
  - internally selects between the FIFO and the depth-1 register under `INTC_KBD_FIFO_EN`.
- Top level holds the timer, the FSM, and the sticky flags.

## Test plan
- Reset with `TIMER_DIV`=8 and `ENABLE`=1, no service: `INT_IRQ`=2'b11 during reset; `timerPend` rises one cycle after the 8th clock and `INT_IRQ`=2'b00 one cycle after that; ignoring it until the next tick sets `TIMER_OVERRUN`=1.
- Strobe `KBD_CODE`=8'h77: two cycles later `INT_IRQ`=2'b01 and `KBD_KEY`=8'h77. `INT_IACK` gives 2'b11 next cycle; `INT_IEND` makes the buffer empty and `KBD_KEY`=8'h00.
- Tick and strobe (8'h20) pending together: timer is served first (2'b00); after its `INT_IEND` there is one IDLE cycle, then 2'b01 with `KBD_KEY`=8'h20.
- With FIFO_EN and depth 4, strobe 8'h69, 8'h6B, 8'h73, 8'h77, 8'h20 without service: `KBD_OVERFLOW`=1. Services return 69, 6B, 73, 77, then `INT_IRQ` stays 2'b11.
- `RESET_N` low while in SVC with 2 keys buffered: immediately `INT_IRQ`=2'b11, `KBD_KEY`=8'h00, flags 0. A subsequent stray `INT_IEND` has no effect.
- `ENABLE`=0 with a pending strobe 8'h73: `INT_IRQ` stays 2'b11. Raising `ENABLE` gives 2'b01 one cycle later; an `INT_IEND` issued in REQ is ignored.

Source files
------------

// File: rtl/intc_pkg.sv
// ============================================================================
// Module   : intc_pkg
// Purpose  : Shared request codes, FSM states and source encoding for the
//            pong interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package intc_pkg;

    localparam logic [1:0] IRQ_TIMER = 2'b00;
    localparam logic [1:0] IRQ_KBD   = 2'b01;
    localparam logic [1:0] IRQ_NONE  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        SVC  = 2'b10
    } intcState_t;

    typedef enum logic {
        SRC_TIMER = 1'b0,
        SRC_KBD   = 1'b1
    } intcSrc_t;

    function automatic logic [1:0] srcToIrq(input intcSrc_t src);
        return (src == SRC_TIMER) ? IRQ_TIMER : IRQ_KBD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/intc_key_fifo.sv
// ============================================================================
// Module   : intc_key_fifo
// Purpose  : Keystroke buffer. INTC_KBD_FIFO_EN selects a DEPTH-entry FIFO;
//            otherwise a single holding register is used.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module intc_key_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] data,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);

`ifdef INTC_KBD_FIFO_EN
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);

    logic [7:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_doPush;
    logic               w_doPop;

    // A pop frees a slot in the same cycle, so push on full is accepted then.
    assign w_doPop  = pop && !empty;
    assign w_doPush = push && (!full || w_doPop);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + c_PTR_ONE;
            if (w_doPop)  r_rdPtr <= r_rdPtr + c_PTR_ONE;
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_doPush) r_mem[r_wrPtr] <= data;
    end

    assign empty = (r_count == '0);
    assign full  = (r_count == c_CNT_FULL);
    assign head  = empty ? 8'h00 : r_mem[r_rdPtr];
`else
    logic       r_valid;
    logic [7:0] r_data;
    logic       w_doPush;
    logic       w_doPop;

    assign w_doPop  = pop && r_valid;
    assign w_doPush = push && (!r_valid || w_doPop);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_valid <= 1'b0;
            r_data  <= 8'h00;
        end else if (w_doPush) begin
            r_valid <= 1'b1;
            r_data  <= data;
        end else if (w_doPop) begin
            r_valid <= 1'b0;
        end
    end

    // Single slot: the requested depth only has to be non-zero here.
    assign empty = !r_valid;
    assign full  = r_valid && (DEPTH != 0);
    assign head  = r_valid ? r_data : 8'h00;
`endif

endmodule

`default_nettype wire

// File: rtl/interrupt_controller.sv
// ============================================================================
// Module   : interrupt_controller
// Purpose  : IRQ/IACK/IEND responder: system timer, keystroke buffer, request
//            FSM and sticky error flags. Option macro: INTC_KBD_FIFO_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module interrupt_controller
    import intc_pkg::*;
#(
    parameter logic [15:0] TIMER_DIV      = 16'd50000,
    parameter int          KBD_FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       ENABLE,
    input  logic       KBD_STROBE,
    input  logic [7:0] KBD_CODE,
    output logic [1:0] INT_IRQ,
    input  logic       INT_IACK,
    input  logic       INT_IEND,
    output logic [7:0] KBD_KEY,
    output logic       TIMER_OVERRUN,
    output logic       KBD_OVERFLOW,
    input  logic       CLEAR_FLAGS
);

    localparam logic [15:0] c_TICK_AT = TIMER_DIV - 16'd1;

    logic [15:0] r_timerCnt;
    logic        r_timerPend;
    intcState_t  r_state;
    intcSrc_t    r_sel;
    logic [1:0]  r_irq;
    logic        r_timerOverrun;
    logic        r_kbdOverflow;

    logic        w_tick;
    logic        w_kbdEmpty;
    logic        w_kbdFull;
    logic        w_kbdPend;
    logic        w_endSvc;
    logic        w_timerDone;
    logic        w_kbdPop;
    logic        w_setOverrun;
    logic        w_setOverflow;
    intcSrc_t    w_pickSel;

    assign w_tick      = (r_timerCnt == c_TICK_AT);
    assign w_kbdPend   = !w_kbdEmpty;
    assign w_endSvc    = (r_state == SVC) && INT_IEND;
    assign w_timerDone = w_endSvc && (r_sel == SRC_TIMER);
    assign w_kbdPop    = w_endSvc && (r_sel == SRC_KBD);
    assign w_pickSel   = r_timerPend ? SRC_TIMER : SRC_KBD;

    // A tick coinciding with the timer's own end-of-interrupt just re-arms it.
    assign w_setOverrun  = w_tick && r_timerPend && !w_timerDone;
    assign w_setOverflow = KBD_STROBE && w_kbdFull && !w_kbdPop;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_timerCnt  <= 16'd0;
            r_timerPend <= 1'b0;
        end else begin
            r_timerCnt <= w_tick ? 16'd0 : r_timerCnt + 16'd1;
            if (w_tick) begin
                r_timerPend <= 1'b1;
            end else if (w_timerDone) begin
                r_timerPend <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
            r_sel   <= SRC_TIMER;
            r_irq   <= IRQ_NONE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ENABLE && (r_timerPend || w_kbdPend)) begin
                        r_state <= REQ;
                        r_sel   <= w_pickSel;
                        r_irq   <= srcToIrq(w_pickSel);
                    end
                end
                REQ: begin
                    if (INT_IACK) begin
                        r_state <= SVC;
                        r_irq   <= IRQ_NONE;
                    end
                end
                SVC: begin
                    if (INT_IEND) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_irq   <= IRQ_NONE;
                end
            endcase
        end
    end

    // Set events take precedence over a same-cycle clear.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_timerOverrun <= 1'b0;
            r_kbdOverflow  <= 1'b0;
        end else begin
            if (w_setOverrun) begin
                r_timerOverrun <= 1'b1;
            end else if (CLEAR_FLAGS) begin
                r_timerOverrun <= 1'b0;
            end
            if (w_setOverflow) begin
                r_kbdOverflow <= 1'b1;
            end else if (CLEAR_FLAGS) begin
                r_kbdOverflow <= 1'b0;
            end
        end
    end

    intc_key_fifo #(
        .DEPTH (KBD_FIFO_DEPTH)
    ) u_keyFifo (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .push    (KBD_STROBE),
        .pop     (w_kbdPop),
        .data    (KBD_CODE),
        .head    (KBD_KEY),
        .empty   (w_kbdEmpty),
        .full    (w_kbdFull)
    );

    assign INT_IRQ       = r_irq;
    assign TIMER_OVERRUN = r_timerOverrun;
    assign KBD_OVERFLOW  = r_kbdOverflow;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_controller.sv
// ============================================================================
// Module   : tb_interrupt_controller
// Purpose  : Directed, table-driven bench for interrupt_controller; a slow-timer
//            instance exercises the keyboard path, a fast-timer one the timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_interrupt_controller;

`ifdef INTC_KBD_FIFO_EN
    localparam int EXP_DEPTH = 4;
`else
    localparam int EXP_DEPTH = 1;
`endif

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       ENABLE = 1'b1;
    logic       KBD_STROBE = 1'b0;
    logic [7:0] KBD_CODE = 8'h00;
    logic       INT_IACK = 1'b0;
    logic       INT_IEND = 1'b0;
    logic       CLEAR_FLAGS = 1'b0;

    logic [1:0] kIrq, tIrq;
    logic [7:0] kKey, tKey;
    logic       kTov, tTov, kKov, tKov;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    interrupt_controller #(.TIMER_DIV(16'd65535), .KBD_FIFO_DEPTH(4)) u_dutK (
        .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .KBD_STROBE(KBD_STROBE),
        .KBD_CODE(KBD_CODE), .INT_IRQ(kIrq), .INT_IACK(INT_IACK), .INT_IEND(INT_IEND),
        .KBD_KEY(kKey), .TIMER_OVERRUN(kTov), .KBD_OVERFLOW(kKov), .CLEAR_FLAGS(CLEAR_FLAGS)
    );

    interrupt_controller #(.TIMER_DIV(16'd8), .KBD_FIFO_DEPTH(4)) u_dutT (
        .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .KBD_STROBE(KBD_STROBE),
        .KBD_CODE(KBD_CODE), .INT_IRQ(tIrq), .INT_IACK(INT_IACK), .INT_IEND(INT_IEND),
        .KBD_KEY(tKey), .TIMER_OVERRUN(tTov), .KBD_OVERFLOW(tKov), .CLEAR_FLAGS(CLEAR_FLAGS)
    );

    typedef struct {
        logic       rstN;
        logic       en;
        logic       stb;
        logic [7:0] code;
        logic       iack;
        logic       iend;
        logic [1:0] irq;
        logic [7:0] key;
    } vec_t;

    vec_t tbl[31];

    function automatic vec_t mk(input logic rstN, en, stb, input logic [7:0] code,
                                input logic iack, iend, input logic [1:0] irq,
                                input logic [7:0] key);
        vec_t v;
        v.rstN = rstN; v.en = en; v.stb = stb; v.code = code;
        v.iack = iack; v.iend = iend; v.irq = irq; v.key = key;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and return 1 time unit after the next rising edge.
    task automatic cyc(input logic stb, input logic [7:0] code, input logic iack,
                       input logic iend, input logic clr);
        KBD_STROBE = stb; KBD_CODE = code; INT_IACK = iack; INT_IEND = iend; CLEAR_FLAGS = clr;
        @(posedge CLK); #1;
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        RESET_N = 1'b0;
        KBD_STROBE = 1'b0; KBD_CODE = 8'h00; INT_IACK = 1'b0; INT_IEND = 1'b0; CLEAR_FLAGS = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET_N = 1'b1;
    endtask

    task automatic serveKey(input logic [7:0] exp);
        int n = 0;
        do begin
            idle();
            n++;
        end while (kIrq != 2'b01 && n < 4);
        chk("svc irq", 8'(kIrq), 8'h01);
        chk("svc key", kKey, exp);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("svc key after iack", kKey, exp);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("svc irq after iend", 8'(kIrq), 8'h03);
    endtask

    initial begin
        logic [7:0] codes [5];
        codes[0] = 8'h69; codes[1] = 8'h6B; codes[2] = 8'h73; codes[3] = 8'h77; codes[4] = 8'h20;

        //            rstN en stb code   iack iend irq    key
        tbl[0]  = mk(1'b0, 1, 0, 8'h00, 0, 0, 2'b11, 8'h00);
        tbl[1]  = mk(1'b0, 1, 0, 8'h00, 0, 0, 2'b11, 8'h00);
        tbl[2]  = mk(1'b1, 1, 0, 8'h00, 0, 0, 2'b11, 8'h00);
        tbl[3]  = mk(1'b1, 1, 1, 8'h77, 0, 0, 2'b11, 8'h77);
        tbl[4]  = mk(1'b1, 1, 0, 8'h00, 0, 0, 2'b01, 8'h77);
        tbl[5]  = mk(1'b1, 1, 0, 8'h00, 0, 0, 2'b01, 8'h77);
        tbl[6]  = mk(1'b1, 1, 0, 8'h00, 1, 0, 2'b11, 8'h77);
        tbl[7]  = mk(1'b1, 1, 0, 8'h00, 0, 0, 2'b11, 8'h77);
        tbl[8]  = mk(1'b1, 1, 0, 8'h00, 0, 1, 2'b11, 8'h00);
        tbl[9]  = mk(1'b1, 1, 0, 8'h00, 0, 0, 2'b11, 8'h00);
        tbl[10] = mk(1'b1, 0, 1, 8'h73, 0, 0, 2'b11, 8'h73);
        tbl[11] = mk(1'b1, 0, 0, 8'h00, 0, 0, 2'b11, 8'h73);
        tbl[12] = mk(1'b1, 0, 0, 8'h00, 0, 0, 2'b11, 8'h73);
        tbl[13] = mk(1'b1, 1, 0, 8'h00, 0, 0, 2'b01, 8'h73);
        tbl[14] = mk(1'b1, 1, 0, 8'h00, 0, 1, 2'b01, 8'h73);
        tbl[15] = mk(1'b1, 1, 0, 8'h00, 1, 0, 2'b11, 8'h73);
        tbl[16] = mk(1'b1, 1, 0, 8'h00, 0, 1, 2'b11, 8'h00);
        tbl[17] = mk(1'b1, 1, 0, 8'h00, 1, 0, 2'b11, 8'h00);
        tbl[18] = mk(1'b1, 1, 1, 8'h41, 0, 0, 2'b11, 8'h41);
        tbl[19] = mk(1'b1, 1, 0, 8'h00, 0, 0, 2'b01, 8'h41);
        tbl[20] = mk(1'b1, 0, 0, 8'h00, 0, 0, 2'b01, 8'h41);
        tbl[21] = mk(1'b1, 0, 0, 8'h00, 1, 0, 2'b11, 8'h41);
        tbl[22] = mk(1'b1, 0, 0, 8'h00, 0, 1, 2'b11, 8'h00);
        tbl[23] = mk(1'b1, 1, 0, 8'h00, 0, 0, 2'b11, 8'h00);
        tbl[24] = mk(1'b1, 1, 1, 8'h31, 0, 0, 2'b11, 8'h31);
        tbl[25] = mk(1'b1, 1, 0, 8'h00, 0, 0, 2'b01, 8'h31);
        tbl[26] = mk(1'b1, 1, 0, 8'h00, 1, 0, 2'b11, 8'h31);
        tbl[27] = mk(1'b1, 1, 1, 8'h32, 0, 1, 2'b11, 8'h32);
        tbl[28] = mk(1'b1, 1, 0, 8'h00, 0, 0, 2'b01, 8'h32);
        tbl[29] = mk(1'b1, 1, 0, 8'h00, 1, 0, 2'b11, 8'h32);
        tbl[30] = mk(1'b1, 1, 0, 8'h00, 0, 1, 2'b11, 8'h00);

        #2;
        for (int i = 0; i < 31; i++) begin
            RESET_N = tbl[i].rstN;
            ENABLE  = tbl[i].en;
            cyc(tbl[i].stb, tbl[i].code, tbl[i].iack, tbl[i].iend, 1'b0);
            chk($sformatf("vec%0d irq", i), 8'(kIrq), 8'(tbl[i].irq));
            chk($sformatf("vec%0d key", i), kKey, tbl[i].key);
            chk($sformatf("vec%0d kovf", i), 8'(kKov), 8'h00);
        end

        // Timer tick, priority-free request and overrun, on the fast-timer instance.
        ENABLE = 1'b1;
        RESET_N = 1'b0;
        #1;
        chk("tmr irq in reset", 8'(tIrq), 8'h03);
        doReset();
        for (int e = 1; e <= 16; e++) begin
            idle();
            chk($sformatf("tmr irq e%0d", e), 8'(tIrq), (e <= 8) ? 8'h03 : 8'h00);
            chk($sformatf("tmr ovr e%0d", e), 8'(tTov), (e == 16) ? 8'h01 : 8'h00);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("tmr ovr cleared", 8'(tTov), 8'h00);
        repeat (6) idle();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("tmr ovr set beats clear", 8'(tTov), 8'h01);

        // Tick and strobe pending together: timer first, then keyboard.
        doReset();
        repeat (7) idle();
        cyc(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
        chk("both pend irq", 8'(tIrq), 8'h03);
        idle();
        chk("both timer first", 8'(tIrq), 8'h00);
        chk("both key held", tKey, 8'h20);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("both iack", 8'(tIrq), 8'h03);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("both idle gap", 8'(tIrq), 8'h03);
        idle();
        chk("both kbd next", 8'(tIrq), 8'h01);
        chk("both kbd key", tKey, 8'h20);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("both key popped", tKey, 8'h00);
        repeat (2) idle();
        idle();
        chk("tick re-request", 8'(tIrq), 8'h00);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (5) idle();
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("tick+iend irq", 8'(tIrq), 8'h03);
        chk("tick+iend no ovr", 8'(tTov), 8'h00);
        idle();
        chk("tick+iend pend kept", 8'(tIrq), 8'h00);
        chk("tmr kovf quiet", 8'(tKov), 8'h00);

        // Five strobes without service.
        ENABLE = 1'b0;
        doReset();
        for (int k = 0; k < 5; k++) cyc(1'b1, codes[k], 1'b0, 1'b0, 1'b0);
        chk("burst kovf", 8'(kKov), 8'h01);
        chk("burst head", kKey, 8'h69);
        ENABLE = 1'b1;
        for (int k = 0; k < EXP_DEPTH; k++) serveKey(codes[k]);
        for (int k = 0; k < 4; k++) begin
            idle();
            chk("drained irq", 8'(kIrq), 8'h03);
        end
        chk("drained key", kKey, 8'h00);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("kovf cleared", 8'(kKov), 8'h00);
        ENABLE = 1'b0;
        for (int k = 0; k < EXP_DEPTH; k++) cyc(1'b1, 8'(k + 1), 1'b0, 1'b0, 1'b0);
        chk("full no kovf", 8'(kKov), 8'h00);
        cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
        chk("kovf set beats clear", 8'(kKov), 8'h01);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("kovf clear again", 8'(kKov), 8'h00);

        // Asynchronous reset in SVC with keys buffered.
        ENABLE = 1'b1;
        doReset();
        cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        chk("rst pre irq", 8'(kIrq), 8'h01);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("rst pre svc", 8'(kIrq), 8'h03);
        chk("rst pre kovf", 8'(kKov), (EXP_DEPTH == 1) ? 8'h01 : 8'h00);
        RESET_N = 1'b0;
        #1;
        chk("rst async irq", 8'(kIrq), 8'h03);
        chk("rst async key", kKey, 8'h00);
        chk("rst async kovf", 8'(kKov), 8'h00);
        chk("rst async tovr", 8'(kTov), 8'h00);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("stray iend irq", 8'(kIrq), 8'h03);
        chk("stray iend key", kKey, 8'h00);
        idle();
        chk("stray iend idle", 8'(kIrq), 8'h03);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
